// File: rtl/proc_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared constants and types for the processor control unit.
//               Covers the bus/register geometry, instruction field
//               positions, opcodes and timestep encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

  localparam int NREG   = 8;
  localparam int REG_W  = 3;
  localparam int DATA_W = 16;
  localparam int IR_W   = 9;

  // Instruction format III XXX YYY
  localparam int OP_HI = 8;
  localparam int OP_LO = 6;
  localparam int RX_HI = 5;
  localparam int RX_LO = 3;
  localparam int RY_HI = 2;
  localparam int RY_LO = 0;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/proc_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : proc_ctrl_if
// Description : Control bundle between the sequencer and the datapath:
//               run/din going in, register/bus enables coming out.
//               master = controller side, slave = datapath side.
// Revision    : 1.0 - initial release
// ============================================================================
interface proc_ctrl_if;
  import proc_pkg::*;

  logic              run;
  logic [DATA_W-1:0] din;
  logic              ir_in;
  logic [NREG-1:0]   r_in;
  logic [NREG-1:0]   r_out;
  logic              a_in;
  logic              g_in;
  logic              g_out;
  logic              din_out;
  logic              addsub;
  logic              done;
  logic              busy;

  modport master (
    input  run, din,
    output ir_in, r_in, r_out, a_in, g_in, g_out, din_out, addsub, done, busy
  );

  modport slave (
    output run, din,
    input  ir_in, r_in, r_out, a_in, g_in, g_out, din_out, addsub, done, busy
  );

endinterface
`default_nettype wire

// File: rtl/proc_control_unit_dec3to8.sv
`default_nettype none
// ============================================================================
// Module      : dec3to8
// Description : 3-to-8 one-hot decoder with enable; all-zero when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  // One output bit per code value, gated by the enable
  generate
    for (genvar i = 0; i < 8; i++) begin : g_dec
      assign y[i] = en && (sel == 3'(i));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/proc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : proc_control_unit
// Description : Timestep sequencer (T0..T3) for the 16-bit bus processor.
//               Captures the instruction in T0 and decodes (state, IR, run)
//               into register load enables and a single bus driver select.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_control_unit
  import proc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  proc_ctrl_if.master bus
);

  state_t          state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;

  logic [2:0] op, rx, ry;
  logic       is_alu;

  logic            ir_in, a_in, g_in, g_out, din_out, addsub, done, busy;
  logic            rin_en, rout_en;
  logic [2:0]      rout_sel;
  logic [NREG-1:0] r_in, r_out;

  // Only the low IR_W bits of din carry an instruction
  logic unused_din;
  assign unused_din = ^bus.din[DATA_W-1:IR_W];

  assign op     = ir_q[OP_HI:OP_LO];
  assign rx     = ir_q[RX_HI:RX_LO];
  assign ry     = ir_q[RY_HI:RY_LO];
  assign is_alu = (op == OP_ADD) || (op == OP_SUB);

  // Next timestep and instruction capture; run is only honoured in T0
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      T0: begin
        if (bus.run) begin
          state_d = T1;
          ir_d    = bus.din[IR_W-1:0];
        end
      end
      T1:      state_d = is_alu ? T2 : T0;
      T2:      state_d = T3;
      T3:      state_d = T0;
      default: state_d = T0;
    endcase
  end

  // State and IR flops; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Control decode; everything forced low while reset is asserted
  always_comb begin
    ir_in    = 1'b0;
    a_in     = 1'b0;
    g_in     = 1'b0;
    g_out    = 1'b0;
    din_out  = 1'b0;
    addsub   = 1'b0;
    done     = 1'b0;
    busy     = 1'b0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = rx;
    if (rst_n) begin
      busy = (state_q != T0);
      case (state_q)
        T0: ir_in = bus.run;
        T1: begin
          case (op)
            OP_MV: begin
              rout_en  = 1'b1;
              rout_sel = ry;
              rin_en   = 1'b1;
              done     = 1'b1;
            end
            OP_MVI: begin
              din_out = 1'b1;
              rin_en  = 1'b1;
              done    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              rout_en  = 1'b1;
              rout_sel = rx;
              a_in     = 1'b1;
            end
            default: done = 1'b1;
          endcase
        end
        T2: begin
          if (is_alu) begin
            rout_en  = 1'b1;
            rout_sel = ry;
            g_in     = 1'b1;
            addsub   = (op == OP_SUB);
          end
        end
        T3: begin
          if (is_alu) begin
            g_out  = 1'b1;
            rin_en = 1'b1;
            done   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Destination register is always the X field
  dec3to8 u_dec_rin (
    .en  (rin_en),
    .sel (rx),
    .y   (r_in)
  );

  // Bus source is X or Y depending on the timestep
  dec3to8 u_dec_rout (
    .en  (rout_en),
    .sel (rout_sel),
    .y   (r_out)
  );

  assign bus.ir_in   = ir_in;
  assign bus.r_in    = r_in;
  assign bus.r_out   = r_out;
  assign bus.a_in    = a_in;
  assign bus.g_in    = g_in;
  assign bus.g_out   = g_out;
  assign bus.din_out = din_out;
  assign bus.addsub  = addsub;
  assign bus.done    = done;
  assign bus.busy    = busy;

endmodule
`default_nettype wire
